// File: rtl/rsa_link_tester_if.sv
// rsa_link_tester_if: byte-level UART transmit/receive handshake between tester and link
interface rsa_link_tester_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  modport master (output tx_data, tx_start, input tx_busy, rx_data, rx_ready);
  modport slave  (input tx_data, tx_start, output tx_busy, rx_data, rx_ready);
endinterface

// File: rtl/rsa_link_tester.sv
// rsa_link_tester: sends a plaintext range over UART and checks each reply against a local modexp
module rsa_link_tester #(
  parameter int WIDTH_N     = 8,
  parameter int WIDTH_DEG   = 8,
  parameter int N_VAL       = 33,
  parameter int EXP_VAL     = 7,
  parameter int MSG_FIRST   = 0,
  parameter int MSG_LAST    = 32,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  rsa_link_tester_if.master   lnk,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [WIDTH_N-1:0]  first_fail
);
  localparam int CW = $clog2(WIDTH_DEG + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = 2 * WIDTH_N;
  localparam logic [PW-1:0] NW = PW'(N_VAL);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, SEND, WAIT_RX, CHECK, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH_N-1:0] msg_q, msg_d, acc_q, acc_d, base_q, base_d, rxd_q, rxd_d, txd_q, txd_d, ff_q, ff_d;
  logic [WIDTH_DEG-1:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] err_q, err_d;
  logic txs_q, txs_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic fail;
  logic [PW-1:0] pab, pbb;
  assign pab = PW'(acc_q) * PW'(base_q);
  assign pbb = PW'(base_q) * PW'(base_q);
  assign lnk.tx_data  = 8'(txd_q);
  assign lnk.tx_start = txs_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  // sequencing, square-and-multiply datapath, reply capture and error bookkeeping
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rxd_d   = rxd_q;
    txd_d   = txd_q;
    ff_d    = ff_q;
    err_d   = err_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    txs_d   = 1'b0;
    done_d  = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        msg_d   = WIDTH_N'(MSG_FIRST);
        err_d   = '0;
        ff_d    = '0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        acc_d   = WIDTH_N'(1);
        base_d  = WIDTH_N'(PW'(msg_q) % NW);
        exp_d   = WIDTH_DEG'(EXP_VAL);
        cnt_d   = CW'(WIDTH_DEG);
        state_d = CALC;
      end
      CALC: begin
        acc_d   = exp_q[0] ? WIDTH_N'(pab % NW) : acc_q;
        base_d  = WIDTH_N'(pbb % NW);
        exp_d   = exp_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? SEND : CALC;
      end
      SEND: if (!lnk.tx_busy) begin
        txs_d   = 1'b1;
        txd_d   = msg_q;
        tmo_d   = '0;
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        tmo_d = tmo_q + TW'(1);
        if (lnk.rx_ready) begin
          rxd_d   = lnk.rx_data[WIDTH_N-1:0];
          state_d = CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          fail    = 1'b1;
          state_d = NEXT;
        end
      end
      CHECK: begin
        fail    = rxd_q != acc_q;
        state_d = NEXT;
      end
      NEXT: begin
        msg_d   = (msg_q == WIDTH_N'(MSG_LAST)) ? msg_q : msg_q + WIDTH_N'(1);
        state_d = (msg_q == WIDTH_N'(MSG_LAST)) ? FIN : LOAD;
      end
      FIN: begin
        done_d  = 1'b1;
        pass_d  = err_q == '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      ff_d  = (err_q == '0) ? msg_q : ff_q;
    end
  end
  // state and datapath registers; reset returns everything to a quiet idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rxd_q   <= '0;
      txd_q   <= '0;
      ff_q    <= '0;
      err_q   <= '0;
      txs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rxd_q   <= rxd_d;
      txd_q   <= txd_d;
      ff_q    <= ff_d;
      err_q   <= err_d;
      txs_q   <= txs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
endmodule

// File: tb/tb_rsa_link_tester.sv
// tb_rsa_link_tester: randomized responder with scoreboarded transmit bytes and run summaries
module tb_rsa_link_tester;
  logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;
  rsa_link_tester_if i0 ();
  rsa_link_tester_if i1 ();
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1;
  logic [7:0] ff0, ff1;
  rsa_link_tester #(.TIMEOUT_CYC(100)) u0 (
    .clk(clk), .reset(reset), .start(start0), .lnk(i0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );
  rsa_link_tester #(.EXP_VAL(13), .MSG_FIRST(29), .MSG_LAST(29), .TIMEOUT_CYC(100)) u1 (
    .clk(clk), .reset(reset), .start(start1), .lnk(i1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
  );
  typedef struct {int p; int e; int f;} sum_t;
  int txq[$];
  sum_t dq[$];
  int checks = 0, fails = 0;
  int bad_m = -1, silent_m = -1, hold_m = -1, spur_m = -1;
  bit late = 1'b0;
  int cyc = 0, ndone0 = 0, ndone1 = 0, seen1 = -1, last_m = -1, last_cyc = 0;
  logic pbusy = 1'b0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int pw(input int m, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * m) % 33;
    return r;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: pops expected bytes on each send strobe and expected summaries on each done
  always @(negedge clk) begin
    sum_t s;
    if (i0.tx_start) begin
      if (txq.size() == 0) chk("unexpected_tx_start", int'(i0.tx_start), 0);
      else chk("tx_data", int'(i0.tx_data), txq.pop_front());
      chk("tx_start_while_busy", int'(pbusy), 0);
      if (last_m >= 0 && last_m == silent_m) chk("timeout_gap", cyc - last_cyc, 111);
      last_m = int'(i0.tx_data);
      last_cyc = cyc;
    end
    if (done0) begin
      ndone0++;
      if (dq.size() == 0) chk("unexpected_done", int'(done0), 0);
      else begin
        s = dq.pop_front();
        chk("pass", int'(pass0), s.p);
        chk("err_count", int'(err0), s.e);
        chk("first_fail", int'(ff0), s.f);
      end
    end
    pbusy = i0.tx_busy;
    if (i1.tx_start) seen1 = int'(i1.tx_data);
    if (done1) ndone1++;
  end
  // responder for u0: UART busy window, randomized reply delay, optional fault injection
  initial begin
    int m, b, d;
    i0.tx_busy = 1'b0;
    i0.rx_ready = 1'b0;
    i0.rx_data = '0;
    forever begin
      @(negedge clk);
      if (i0.tx_start) begin
        m = int'(i0.tx_data);
        b = int'($urandom_range(1, 8));
        d = late ? 15 : int'($urandom_range(1, 10));
        @(posedge clk); #1 i0.tx_busy = 1'b1;
        repeat (b) @(posedge clk);
        #1 i0.tx_busy = 1'b0;
        if (m != silent_m) begin
          repeat (d) @(posedge clk);
          #1 i0.rx_data = (m == bad_m) ? 8'd0 : 8'(pw(m, 7));
          i0.rx_ready = 1'b1;
          @(posedge clk); #1 i0.rx_ready = 1'b0;
          if (m == hold_m) begin
            i0.tx_busy = 1'b1;
            repeat (50) @(posedge clk);
            #1 i0.tx_busy = 1'b0;
          end
          if (m == spur_m) begin
            repeat (4) @(posedge clk);
            #1 i0.rx_data = 8'hAA;
            i0.rx_ready = 1'b1;
            @(posedge clk); #1 i0.rx_ready = 1'b0;
          end
        end
      end
    end
  end
  // responder for u1: always answers with the known ciphertext 29^13 mod 33 = 2
  initial begin
    i1.tx_busy = 1'b0;
    i1.rx_ready = 1'b0;
    i1.rx_data = '0;
    forever begin
      @(negedge clk);
      if (i1.tx_start) begin
        repeat (3) @(posedge clk);
        #1 i1.rx_data = 8'd2;
        i1.rx_ready = 1'b1;
        @(posedge clk); #1 i1.rx_ready = 1'b0;
      end
    end
  end
  task automatic pulse0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask
  task automatic run(input int bad, input int silent, input int hold, input int spur, input bit mid);
    int e = 0, f = 0, n, t = 0;
    sum_t s;
    bad_m = bad; silent_m = silent; hold_m = hold; spur_m = spur;
    for (int m = 0; m <= 32; m++) begin
      txq.push_back(m);
      if (m == silent || (m == bad && pw(m, 7) != 0)) begin
        if (e == 0) f = m;
        e++;
      end
    end
    s.p = (e == 0) ? 1 : 0; s.e = e; s.f = f;
    dq.push_back(s);
    n = ndone0;
    pulse0();
    @(negedge clk) chk("busy_on_start", int'(busy0), 1);
    if (mid) begin
      repeat (150) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
    end
    while (ndone0 == n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("run_completed", ndone0 - n, 1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", int'(busy0), 0);
  endtask
  initial begin
    int k = 0, t = 0, bad_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_tx_start", int'(i0.tx_start), 0);
    chk("rst_pass1", int'(pass1), 0);
    @(posedge clk); #1 reset = 1'b0;
    run(-1, -1, 10, 20, 1'b1);
    run(5, -1, -1, -1, 1'b0);
    run(-1, 4, -1, -1, 1'b0);
    bad_m = 1; silent_m = -1; hold_m = -1; spur_m = -1; late = 1'b1;
    txq.push_back(0); txq.push_back(1); txq.push_back(2);
    pulse0();
    while (k < 3 && t < 500) begin
      @(negedge clk);
      t++;
      if (i0.tx_start) k++;
    end
    chk("reset_test_reached_wait", k, 3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_err", int'(err0), 0);
    chk("mid_rst_first_fail", int'(ff0), 0);
    chk("mid_rst_tx_data", int'(i0.tx_data), 0);
    chk("mid_rst_pass", int'(pass0), 0);
    repeat (40) begin
      @(negedge clk);
      if (busy0 || err0 != 0 || i0.tx_start) bad_seen = 1;
    end
    chk("idle_after_reset", bad_seen, 0);
    late = 1'b0;
    run(-1, -1, -1, -1, 1'b0);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    t = 0;
    while (ndone1 == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("exp13_done", ndone1, 1);
    chk("exp13_tx_data", seen1, 29);
    chk("exp13_pass", int'(pass1), 1);
    chk("exp13_err", int'(err1), 0);
    chk("txq_drained", txq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
